// File: rtl/press_count_display.sv
// press_count_display: counts debounced switch releases as a two-digit BCD
// value (00..99, wrapping) and drives a time-multiplexed two-digit
// seven-segment display.
// Optional feature macro: PRESS_COUNT_HOLD_CLEAR_EN -- holding the switch for
// HOLD_CYCLES clears the count, and the release ending that hold is not counted.
module press_count_display #(
  parameter int MUX_CYCLES  = 250000,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_switch,
  output logic       o_press,
  output logic       o_wrap,
  output logic [7:0] o_count,
  output logic [6:0] o_segment,
  output logic [1:0] o_digit_sel
);

  localparam int MUX_W = (MUX_CYCLES > 2) ? $clog2(MUX_CYCLES) : 1;
  localparam logic [MUX_W-1:0] MUX_LAST = MUX_W'(MUX_CYCLES - 1);

  // Both periods must be at least two cycles for the counters to make sense.
  generate
    if (MUX_CYCLES < 2 || HOLD_CYCLES < 2) begin : g_bad_param
      $error("press_count_display: MUX_CYCLES and HOLD_CYCLES must be >= 2");
    end
  endgenerate

  // Seven-segment glyph for one BCD digit, bit0=a .. bit6=g, active high.
  function automatic logic [6:0] f_glyph(input logic [3:0] i_digit);
    logic [6:0] v_seg;
    case (i_digit)
      4'd0:    v_seg = 7'b0111111;
      4'd1:    v_seg = 7'b0000110;
      4'd2:    v_seg = 7'b1011011;
      4'd3:    v_seg = 7'b1001111;
      4'd4:    v_seg = 7'b1100110;
      4'd5:    v_seg = 7'b1101101;
      4'd6:    v_seg = 7'b1111101;
      4'd7:    v_seg = 7'b0000111;
      4'd8:    v_seg = 7'b1111111;
      4'd9:    v_seg = 7'b1101111;
      default: v_seg = 7'b0000000;
    endcase
    return v_seg;
  endfunction

  logic       r_switch;
  logic [MUX_W-1:0] r_mux_cnt;
  logic       w_release;
  logic       w_count_event;
  logic       w_clear;
  logic [7:0] w_count_inc;

  // A release is the falling edge of the debounced level.
  assign w_release = r_switch & ~i_switch;

`ifdef PRESS_COUNT_HOLD_CLEAR_EN
  localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_hold_flag;

  // The release that ends a clearing hold is swallowed.
  assign w_count_event = w_release & ~r_hold_flag;
  assign w_clear       = i_switch & (r_hold_cnt == HOLD_LAST);

  // Hold timer: counts high cycles, saturates at the clear point, arms the flag.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold_cnt  <= '0;
      r_hold_flag <= 1'b0;
    end else if (i_switch) begin
      if (r_hold_cnt == HOLD_LAST) begin
        r_hold_flag <= 1'b1;
      end else begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end else begin
      r_hold_cnt <= '0;
      if (w_release) begin
        r_hold_flag <= 1'b0;
      end
    end
  end
`else
  assign w_count_event = w_release;
  assign w_clear       = 1'b0;
`endif

  // BCD increment with carry from ones into tens and wrap 99 -> 00.
  always_comb begin
    w_count_inc = o_count;
    if (o_count[3:0] == 4'd9) begin
      w_count_inc[3:0] = 4'd0;
      w_count_inc[7:4] = (o_count[7:4] == 4'd9) ? 4'd0 : o_count[7:4] + 4'd1;
    end else begin
      w_count_inc[3:0] = o_count[3:0] + 4'd1;
    end
  end

  // Edge-detect register; resets low so a switch held through reset is not a release.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_switch <= 1'b0;
    end else begin
      r_switch <= i_switch;
    end
  end

  // Count register plus one-cycle press/wrap pulses.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count <= 8'h00;
      o_press <= 1'b0;
      o_wrap  <= 1'b0;
    end else begin
      o_press <= w_count_event;
      o_wrap  <= w_count_event & (o_count == 8'h99);
      if (w_clear) begin
        o_count <= 8'h00;
      end else if (w_count_event) begin
        o_count <= w_count_inc;
      end
    end
  end

  // Display mux: switch digit at terminal count and load that digit's glyph together.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mux_cnt   <= '0;
      o_digit_sel <= 2'b01;
      o_segment   <= 7'b0111111;
    end else if (r_mux_cnt == MUX_LAST) begin
      r_mux_cnt   <= '0;
      o_digit_sel <= {o_digit_sel[0], o_digit_sel[1]};
      // Currently on ones means the next digit shown is tens.
      o_segment   <= f_glyph(o_digit_sel[0] ? o_count[7:4] : o_count[3:0]);
    end else begin
      r_mux_cnt <= r_mux_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_press_count_display.sv
// Testbench for press_count_display with MUX_CYCLES=4, HOLD_CYCLES=16.
// Define PRESS_COUNT_HOLD_CLEAR_EN for both files to exercise the hold-clear build.
module tb_press_count_display;

  localparam int MUX  = 4;
  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_switch = 1'b0;
  logic       o_press, o_wrap;
  logic [7:0] o_count;
  logic [6:0] o_segment;
  logic [1:0] o_digit_sel;

  press_count_display #(.MUX_CYCLES(MUX), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_switch(i_switch),
    .o_press(o_press), .o_wrap(o_wrap), .o_count(o_count),
    .o_segment(o_segment), .o_digit_sel(o_digit_sel)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state: count kept as a plain decimal number.
  int m_count, m_hold, m_mux, m_shown;
  bit m_prev_sw, m_flag, m_tens_sel, m_press, m_wrap;
  logic [6:0] glyph [10];

  function automatic logic [7:0] to_bcd(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
  endtask

  task automatic model_reset();
    m_count = 0; m_hold = 0; m_mux = 0; m_shown = 0;
    m_prev_sw = 0; m_flag = 0; m_tens_sel = 0; m_press = 0; m_wrap = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_count"}, 32'(o_count), 32'h00);
    check({tag, "_press"}, 32'(o_press), 32'h0);
    check({tag, "_wrap"},  32'(o_wrap),  32'h0);
    check({tag, "_sel"},   32'(o_digit_sel), 32'h1);
    check({tag, "_seg"},   32'(o_segment), 32'(7'b0111111));
  endtask

  // Advance one clock with the current i_switch, updating the model from the rules.
  task automatic cycle();
    int  old_count;
    bit  rel;
    old_count = m_count;
    rel = m_prev_sw && !i_switch;
    m_press = 0; m_wrap = 0;
`ifdef PRESS_COUNT_HOLD_CLEAR_EN
    if (i_switch) begin
      if (m_hold == HOLD - 1) begin m_count = 0; m_flag = 1; end
      else m_hold++;
    end else m_hold = 0;
`endif
    if (rel) begin
      if (m_flag) m_flag = 0;
      else begin
        m_press = 1;
        m_wrap = (m_count == 99);
        m_count = (m_count + 1) % 100;
      end
    end
    if (m_mux == MUX - 1) begin
      m_mux = 0;
      m_tens_sel = !m_tens_sel;
      m_shown = m_tens_sel ? old_count / 10 : old_count % 10;
    end else m_mux++;
    m_prev_sw = i_switch;
    @(posedge clk);
    #1;
    check("count", 32'(o_count), 32'(to_bcd(m_count)));
    check("press", 32'(o_press), 32'(m_press));
    check("wrap",  32'(o_wrap),  32'(m_wrap));
    check("sel",   32'(o_digit_sel), m_tens_sel ? 32'h2 : 32'h1);
    check("seg",   32'(o_segment), 32'(glyph[m_shown]));
    check("nibbles", 32'(o_count[3:0] <= 4'd9 && o_count[7:4] <= 4'd9), 32'h1);
  endtask

  task automatic run(input bit lvl, input int n);
    i_switch = lvl;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic press(input int hi, input int lo);
    run(1'b1, hi);
    run(1'b0, lo);
  endtask

  // Asynchronous reset applied between edges; checked before the next edge.
  task automatic do_reset(input bit sw);
    i_switch = sw;
    i_rst_n = 1'b0;
    #1;
    check_reset_vals("rst_async");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    i_rst_n = 1'b1;
  endtask

  initial begin
    glyph[0] = 7'b0111111; glyph[1] = 7'b0000110; glyph[2] = 7'b1011011;
    glyph[3] = 7'b1001111; glyph[4] = 7'b1100110; glyph[5] = 7'b1101101;
    glyph[6] = 7'b1111101; glyph[7] = 7'b0000111; glyph[8] = 7'b1111111;
    glyph[9] = 7'b1101111;
    model_reset();
    @(posedge clk); #1;

    // 1: switch held high through reset, then released once.
    do_reset(1'b1);
    run(1'b1, 5);
    check("t1_no_event", 32'(o_count), 32'h00);
    run(1'b0, 1);
    check("t1_press", 32'(o_press), 32'h1);
    check("t1_count", 32'(o_count), 32'h01);
    run(1'b0, 1);
    check("t1_press_end", 32'(o_press), 32'h0);

    // 2: ten 3-high/3-low presses from zero.
    do_reset(1'b0);
    for (int p = 0; p < 10; p++) press(3, 3);
    check("t2_count", 32'(o_count), 32'h10);

    // 3: 100 releases with random timing, wrap on the last.
    do_reset(1'b0);
    for (int p = 0; p < 99; p++) press($urandom_range(1, 3), $urandom_range(1, 3));
    check("t3_99", 32'(o_count), 32'h99);
    run(1'b1, 1);
    run(1'b0, 1);
    check("t3_wrap", 32'(o_wrap), 32'h1);
    check("t3_press", 32'(o_press), 32'h1);
    check("t3_count", 32'(o_count), 32'h00);

    // 4: count 37, display idle.
    do_reset(1'b0);
    for (int p = 0; p < 37; p++) press(1, 1);
    run(1'b0, 8);
    for (int k = 0; k < 16; k++) begin
      run(1'b0, 1);
      check("t4_glyph", 32'(o_segment),
            (o_digit_sel == 2'b10) ? 32'(7'b1001111) : 32'(7'b0000111));
    end

    // 5: fastest legal toggling counts every release.
    for (int k = 0; k < 3; k++) begin
      run(1'b1, 1);
      run(1'b0, 1);
    end
    check("t5_count", 32'(o_count), 32'h40);

    // 6: long hold at 42.
    do_reset(1'b0);
    for (int p = 0; p < 42; p++) press(1, 1);
    check("t6_start", 32'(o_count), 32'h42);
    run(1'b1, 20);
    run(1'b0, 1);
`ifdef PRESS_COUNT_HOLD_CLEAR_EN
    check("t6_cleared", 32'(o_count), 32'h00);
    check("t6_no_press", 32'(o_press), 32'h0);
    run(1'b0, 2);
    press(2, 2);
    check("t6_next", 32'(o_count), 32'h01);
`else
    check("t6_counted", 32'(o_count), 32'h43);
    check("t6_press", 32'(o_press), 32'h1);
    run(1'b0, 2);
    press(2, 2);
    check("t6_next", 32'(o_count), 32'h44);
`endif

    // Random runs of varying length, with a reset mid-operation.
    for (int r = 0; r < 120; r++) begin
      run(1'(r % 2), $urandom_range(1, 20));
      if (r == 60) do_reset(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
